// File: rtl/exec_controller_if.sv
// Instruction handshake, status outputs and register-bank port of the exec controller.
// The controller attaches to the slave modport; its environment attaches to master.
interface exec_controller_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        done;
    logic [15:0] acc_out;
    logic        zero_flag;
    logic        carry_flag;
    logic        illegal;
    logic [3:0]  mem_address;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    modport slave (
        input  instr, instr_valid, mem_rdata,
        output instr_ready, done, acc_out, zero_flag, carry_flag, illegal,
               mem_address, mem_wdata, mem_we
    );

    modport master (
        output instr, instr_valid, mem_rdata,
        input  instr_ready, done, acc_out, zero_flag, carry_flag, illegal,
               mem_address, mem_wdata, mem_we
    );
endinterface

// File: rtl/exec_controller.sv
// Accumulator executor, IDLE->FETCH->EXEC->DONE: fixed 4 cycles per instruction.
// instr_ready only in IDLE; instructions offered while busy are dropped, never queued.
module exec_controller (
    input  logic             clk,
    input  logic             reset,
    exec_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] addr;
        logic [7:0] imm;
    } instr_t;

    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_LDI   = 4'd8;
    localparam logic [3:0] OP_ADDI  = 4'd9;

    state_t      state;
    state_t      state_nxt;
    instr_t      ins;
    logic [3:0]  opcode_q;
    logic [7:0]  imm_q;
    logic [3:0]  addr_q;
    logic [15:0] operand_q;
    logic [15:0] acc_q;
    logic        zero_q;
    logic        carry_q;
    logic [15:0] acc_nxt;
    logic        carry_nxt;
    logic        upd_zero;
    logic [16:0] sum_ext;

    assign ins = bus.instr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode from state only, so reset drops mem_we/done without waiting for a clock.
    always_comb begin
        state_nxt       = state;
        bus.instr_ready = 1'b0;
        bus.done        = 1'b0;
        bus.illegal     = 1'b0;
        bus.mem_we      = 1'b0;
        case (state)
            IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: state_nxt = EXEC;
            EXEC: begin
                bus.mem_we = (opcode_q == OP_STORE);
                state_nxt  = DONE;
            end
            default: begin
                bus.done    = 1'b1;
                bus.illegal = (opcode_q > OP_ADDI);
                state_nxt   = IDLE;
            end
        endcase
    end

    always_comb begin
        acc_nxt   = acc_q;
        carry_nxt = carry_q;
        upd_zero  = 1'b0;
        sum_ext   = '0;
        case (opcode_q)
            OP_LOAD: begin
                acc_nxt  = operand_q;
                upd_zero = 1'b1;
            end
            OP_ADD: begin
                sum_ext   = {1'b0, acc_q} + {1'b0, operand_q};
                acc_nxt   = sum_ext[15:0];
                carry_nxt = sum_ext[16];
                upd_zero  = 1'b1;
            end
            OP_SUB: begin
                acc_nxt   = acc_q - operand_q;
                carry_nxt = (acc_q < operand_q);
                upd_zero  = 1'b1;
            end
            OP_AND: begin
                acc_nxt   = acc_q & operand_q;
                carry_nxt = 1'b0;
                upd_zero  = 1'b1;
            end
            OP_OR: begin
                acc_nxt   = acc_q | operand_q;
                carry_nxt = 1'b0;
                upd_zero  = 1'b1;
            end
            OP_XOR: begin
                acc_nxt   = acc_q ^ operand_q;
                carry_nxt = 1'b0;
                upd_zero  = 1'b1;
            end
            OP_LDI: begin
                acc_nxt  = {8'h00, imm_q};
                upd_zero = 1'b1;
            end
            OP_ADDI: begin
                sum_ext   = {1'b0, acc_q} + {9'h000, imm_q};
                acc_nxt   = sum_ext[15:0];
                carry_nxt = sum_ext[16];
                upd_zero  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_q  <= '0;
            imm_q     <= '0;
            addr_q    <= '0;
            operand_q <= '0;
            acc_q     <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        opcode_q <= ins.opcode;
                        imm_q    <= ins.imm;
                        addr_q   <= ins.addr;
                    end
                end
                FETCH: operand_q <= bus.mem_rdata;
                EXEC: begin
                    acc_q   <= acc_nxt;
                    carry_q <= carry_nxt;
                    if (upd_zero) begin
                        zero_q <= (acc_nxt == 16'h0000);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.acc_out     = acc_q;
    assign bus.mem_wdata   = acc_q;
    assign bus.mem_address = addr_q;
    assign bus.zero_flag   = zero_q;
    assign bus.carry_flag  = carry_q;
endmodule

// File: tb/tb_exec_controller.sv
// Randomized and directed bench for exec_controller against an integer-arithmetic reference model.
module tb_exec_controller;
    logic clk;
    logic reset;
    exec_controller_if bus ();

    exec_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] bank [16];
    logic [15:0] model_mem [16];
    int m_acc;
    int m_z;
    int m_c;
    int errors = 0;
    int checks = 0;

    assign bus.mem_rdata = bank[bus.mem_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // One clock: a write enabled before the edge lands in the bank at that edge.
    task automatic cyc();
        if (bus.mem_we === 1'b1) bank[bus.mem_address] = bus.mem_wdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_exec(input int op, input int a, input int im);
        int opnd;
        int r;
        opnd = int'(model_mem[a]);
        case (op)
            1: begin m_acc = opnd; m_z = (m_acc == 0); end
            2: model_mem[a] = 16'(m_acc);
            3: begin r = m_acc + opnd; m_c = (r > 65535); m_acc = r % 65536; m_z = (m_acc == 0); end
            4: begin m_c = (m_acc < opnd); m_acc = (m_acc - opnd + 65536) % 65536; m_z = (m_acc == 0); end
            5: begin m_acc = m_acc & opnd; m_c = 0; m_z = (m_acc == 0); end
            6: begin m_acc = m_acc | opnd; m_c = 0; m_z = (m_acc == 0); end
            7: begin m_acc = m_acc ^ opnd; m_c = 0; m_z = (m_acc == 0); end
            8: begin m_acc = im; m_z = (m_acc == 0); end
            9: begin r = m_acc + im; m_c = (r > 65535); m_acc = r % 65536; m_z = (m_acc == 0); end
            default: ;
        endcase
    endtask

    task automatic preload(input int a, input logic [15:0] v);
        bank[a] = v;
        model_mem[a] = v;
    endtask

    // Issues one instruction and checks it cycle by cycle; called and returns at a negedge.
    task automatic run_instr(input int op, input int a, input int im);
        int waitc = 0;
        while (bus.instr_ready !== 1'b1 && waitc < 20) begin cyc(); waitc++; end
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL ready_wait got=%b exp=1", bus.instr_ready); end
        bus.instr = {4'(op), 4'(a), 8'(im)};
        bus.instr_valid = 1'b1;
        cyc();
        // Busy-time offers carry garbage and must be ignored.
        bus.instr = 16'($urandom);
        checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL fetch_ready got=%b exp=0", bus.instr_ready); end
        checks++; if (bus.mem_address !== 4'(a)) begin errors++; $display("FAIL fetch_addr got=%h exp=%h", bus.mem_address, 4'(a)); end
        checks++; if (bus.mem_we !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL fetch_we_done got=%b%b exp=00", bus.mem_we, bus.done); end
        cyc();
        checks++; if (bus.mem_we !== (op == 2)) begin errors++; $display("FAIL exec_we op=%0d got=%b exp=%b", op, bus.mem_we, (op == 2)); end
        checks++; if (bus.mem_wdata !== 16'(m_acc) || bus.done !== 1'b0) begin errors++; $display("FAIL exec_wdata_done got=%h/%b exp=%h/0", bus.mem_wdata, bus.done, 16'(m_acc)); end
        cyc();
        bus.instr_valid = 1'b0;
        model_exec(op, a, im);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL done_pulse got=%b exp=1", bus.done); end
        checks++; if (bus.illegal !== (op >= 10)) begin errors++; $display("FAIL illegal op=%0d got=%b exp=%b", op, bus.illegal, (op >= 10)); end
        checks++; if (bus.acc_out !== 16'(m_acc)) begin errors++; $display("FAIL acc op=%0d got=%h exp=%h", op, bus.acc_out, 16'(m_acc)); end
        checks++; if (bus.zero_flag !== 1'(m_z) || bus.carry_flag !== 1'(m_c)) begin errors++; $display("FAIL flags op=%0d got z=%b c=%b exp z=%0d c=%0d", op, bus.zero_flag, bus.carry_flag, m_z, m_c); end
        checks++; if (bus.mem_we !== 1'b0 || bus.instr_ready !== 1'b0) begin errors++; $display("FAIL done_we_ready got=%b%b exp=00", bus.mem_we, bus.instr_ready); end
        if (op == 2) begin
            checks++; if (bank[a] !== model_mem[a]) begin errors++; $display("FAIL store_bank got=%h exp=%h", bank[a], model_mem[a]); end
        end
        cyc();
        checks++; if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0 || bus.illegal !== 1'b0) begin errors++; $display("FAIL idle_state got rdy=%b done=%b ill=%b exp 1,0,0", bus.instr_ready, bus.done, bus.illegal); end
        checks++; if (bus.mem_address !== 4'(a)) begin errors++; $display("FAIL addr_hold got=%h exp=%h", bus.mem_address, 4'(a)); end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++; if (bus.acc_out !== 16'h0 || bus.zero_flag !== 1'b0 || bus.carry_flag !== 1'b0) begin errors++; $display("FAIL %s_acc_flags got=%h z=%b c=%b exp 0000,0,0", tag, bus.acc_out, bus.zero_flag, bus.carry_flag); end
        checks++; if (bus.done !== 1'b0 || bus.illegal !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL %s_pulses got done=%b ill=%b we=%b exp 0", tag, bus.done, bus.illegal, bus.mem_we); end
        checks++; if (bus.mem_address !== 4'h0 || bus.instr_ready !== 1'b1) begin errors++; $display("FAIL %s_addr_ready got=%h/%b exp=0/1", tag, bus.mem_address, bus.instr_ready); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = 16'h0;
        for (int i = 0; i < 16; i++) preload(i, 16'h0);
        m_acc = 0; m_z = 0; m_c = 0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ldi();
        run_instr(8, 2, 8'h34);
    endtask

    task automatic test_store_load();
        run_instr(8, 0, 8'hFF);
        run_instr(2, 5, 0);
        bank[5] = 16'h0;
        bank[5] = model_mem[5];
        run_instr(8, 0, 8'h00);
        run_instr(1, 5, 0);
        checks++; if (bus.acc_out !== 16'h00FF) begin errors++; $display("FAIL load_back got=%h exp=00ff", bus.acc_out); end
    endtask

    task automatic test_arith();
        preload(3, 16'hFFFF);
        preload(4, 16'h0001);
        run_instr(1, 3, 0);
        run_instr(3, 4, 0);
        checks++; if (bus.acc_out !== 16'h0000 || bus.carry_flag !== 1'b1 || bus.zero_flag !== 1'b1) begin errors++; $display("FAIL add_wrap got=%h c=%b z=%b exp 0000,1,1", bus.acc_out, bus.carry_flag, bus.zero_flag); end
        run_instr(4, 4, 0);
        checks++; if (bus.acc_out !== 16'hFFFF || bus.carry_flag !== 1'b1 || bus.zero_flag !== 1'b0) begin errors++; $display("FAIL sub_borrow got=%h c=%b z=%b exp ffff,1,0", bus.acc_out, bus.carry_flag, bus.zero_flag); end
    endtask

    task automatic test_logic_illegal();
        preload(6, 16'h00F0);
        run_instr(8, 0, 8'hF0);
        run_instr(7, 6, 0);
        checks++; if (bus.acc_out !== 16'h0000 || bus.zero_flag !== 1'b1 || bus.carry_flag !== 1'b0) begin errors++; $display("FAIL xor_zero got=%h z=%b c=%b exp 0000,1,0", bus.acc_out, bus.zero_flag, bus.carry_flag); end
        run_instr(8, 0, 8'h5A);
        run_instr(12, 1, 8'h77);
        checks++; if (bus.acc_out !== 16'h005A) begin errors++; $display("FAIL illegal_acc got=%h exp=005a", bus.acc_out); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) preload(i, 16'($urandom));
        for (int n = 0; n < 80; n++) run_instr(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), int'($urandom_range(255, 0)));
    endtask

    // Valid held high with ADDI 1: exactly one acceptance every fourth cycle.
    task automatic test_back_to_back();
        int accepts = 0;
        bus.instr = {4'd9, 4'd3, 8'd1};
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            checks++; if (bus.instr_ready !== (i % 4 == 0)) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", i, bus.instr_ready, (i % 4 == 0)); end
            checks++; if (bus.done !== (i % 4 == 3)) begin errors++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", i, bus.done, (i % 4 == 3)); end
            if (bus.instr_ready === 1'b1) accepts++;
            cyc();
        end
        bus.instr_valid = 1'b0;
        for (int k = 0; k < accepts; k++) model_exec(9, 3, 1);
        checks++; if (bus.acc_out !== 16'(m_acc) || bus.carry_flag !== 1'(m_c) || bus.zero_flag !== 1'(m_z)) begin errors++; $display("FAIL b2b_acc got=%h c=%b z=%b exp %h,%0d,%0d", bus.acc_out, bus.carry_flag, bus.zero_flag, 16'(m_acc), m_c, m_z); end
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_end_ready got=%b exp=1", bus.instr_ready); end
    endtask

    task automatic test_reset_mid_store();
        preload(9, 16'h1234);
        run_instr(8, 0, 8'h55);
        bus.instr = {4'd2, 4'd9, 8'h00};
        bus.instr_valid = 1'b1;
        cyc();
        bus.instr_valid = 1'b0;
        cyc();
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL rst_store_we_pre got=%b exp=1", bus.mem_we); end
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        m_acc = 0; m_z = 0; m_c = 0;
        @(negedge clk);
        cyc();
        reset = 1'b0;
        checks++; if (bank[9] !== 16'h1234) begin errors++; $display("FAIL rst_bank got=%h exp=1234", bank[9]); end
        run_instr(8, 1, 8'h07);
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_store_load();
        test_arith();
        test_logic_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exec_controller.md
EXEC_CONTROLLER -- requirements
Module: exec_controller

Interface
REQ-001: The block SHALL have a single clock; reset SHALL be asynchronous and active-high.
REQ-002: clk  input  1  rising-edge clock.
REQ-003: reset  input  1  asynchronous, active-high; forces reset state immediately.
REQ-004: instr  input  16  instruction word: [15:12] opcode, [11:8] addr, [7:0] imm.
REQ-005: instr_valid  input  1  instr is valid this cycle.
REQ-006: instr_ready  output  1  block can accept an instruction.
REQ-007: done  output  1  one-cycle pulse; instruction retired.
REQ-008: acc_out  output  16  accumulator value.
REQ-009: zero_flag  output  1  accumulator equals 0 after last flag update.
REQ-010: carry_flag  output  1  carry/borrow of last arithmetic op.
REQ-011: illegal  output  1  one-cycle pulse with done when opcode is undefined.
REQ-012: mem_address  output  4  register-bank address, registered.
REQ-013: mem_wdata  output  16  register-bank write data.
REQ-014: mem_we  output  1  register-bank write enable.
REQ-015: mem_rdata  input  16  register-bank combinational read data for mem_address.

Function
REQ-016: The FSM SHALL have states IDLE, FETCH, EXEC, DONE; instr_ready SHALL be 1 only in IDLE.
REQ-017: The block SHALL accept an instruction on a rising edge where state=IDLE and instr_valid=1, latching opcode, imm and loading mem_address<=addr, moving to FETCH.
REQ-018: instr_valid in any non-IDLE state SHALL be ignored (no queuing).
REQ-019: In FETCH the block SHALL capture mem_rdata into an internal operand register at the end of the cycle, then move to EXEC; FETCH SHALL occur for every opcode.
REQ-020: In EXEC the block SHALL apply the opcode, then move to DONE; in DONE, done=1 for exactly one cycle, then IDLE.
REQ-021: Latency: accept at edge N -> done high in the cycle after edge N+2 -> instr_ready high after edge N+3; 4 cycles per instruction, fixed.
REQ-022: Opcodes: 0 NOP; 1 LOAD acc<=operand; 2 STORE mem[addr]<=acc; 3 ADD acc<=acc+operand; 4 SUB acc<=acc-operand; 5 AND; 6 OR; 7 XOR (bitwise with operand); 8 LDI acc<={8'h00,imm}; 9 ADDI acc<=acc+{8'h00,imm}.
REQ-023: Arithmetic SHALL be 16-bit modulo 2^16; ADD/ADDI carry_flag=bit 16 of 17-bit sum; SUB carry_flag=1 iff acc<operand (unsigned borrow).
REQ-024: AND/OR/XOR SHALL clear carry_flag; LOAD/LDI SHALL leave carry_flag unchanged.
REQ-025: zero_flag SHALL update from the new acc on opcodes 1,3-9; NOP/STORE leave both flags unchanged.
REQ-026: STORE: mem_we=1 during EXEC only (exactly one cycle), mem_wdata=acc; mem_we=0 in all other states and opcodes.
REQ-027: mem_wdata SHALL equal acc_out at all times.
REQ-028: Opcodes 10-15 SHALL behave as NOP and assert illegal together with done for that one cycle.
REQ-029: mem_address SHALL hold its last value after DONE until the next acceptance.

Reset
REQ-030: On reset assertion, at any state including mid-instruction, the block SHALL immediately enter IDLE with acc_out=0, zero_flag=0, carry_flag=0, done=0, illegal=0, mem_we=0, mem_address=0, instr_ready=1.
REQ-031: An instruction interrupted by reset SHALL have no further effect; a STORE interrupted in EXEC SHALL drop mem_we combinationally with reset.
REQ-032: After reset deassertion, the first rising edge with instr_valid=1 SHALL be accepted normally.

Verification
REQ-033: LDI imm=0x34 -> acc_out=0x0034, zero=0, done one cycle, exactly 4 cycles from accept to instr_ready.
REQ-034: LDI 0xFF; STORE addr=5 -> mem_we=1 for one cycle with mem_address=5, mem_wdata=0x00FF; LOAD addr=5 with model bank -> acc_out=0x00FF.
REQ-035: acc=0xFFFF (via bank), ADD operand 0x0001 -> acc_out=0x0000, carry=1, zero=1; then SUB operand 0x0001 -> acc_out=0xFFFF, carry=1, zero=0.
REQ-036: acc=0x00F0, XOR operand 0x00F0 -> acc_out=0, zero=1, carry=0; opcode 0xC -> illegal=1 with done, acc unchanged.
REQ-037: instr_valid held high continuously -> one acceptance per 4 cycles, no instruction accepted while instr_ready=0.
REQ-038: Assert reset during EXEC of STORE -> mem_we falls immediately, bank not written, all outputs at reset values, next instruction accepted after deassertion.
